stack_controller: RTL and testbench

- Game-sequencing FSM for the stacking game. It drives the x_register control inputs: spawn position, direction, load and move enable.
- On a player drop, it freezes motion, samples the block position and computes overlap with the block below.
- It then updates width, base position, level and score, and either spawns the next block or ends the game.

---
 rtl/stack_controller.sv | 166 ++++++++++++++++
 tb/tb_stack_controller.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_controller.sv
// stack_controller: game-sequencing FSM for the stacking game.
// Drives the x_register controls (spawn position, direction, load strobes and
// move enable), evaluates the overlap of a dropped block with the block below
// and keeps width, base position, level and score up to date.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   sync                  VGA frame sync (no influence on this FSM)
//   start                 begins a new game from IDLE, GAME_OVER or WIN
//   drop                  single-cycle drop pulse, honoured only in MOVE
//   curr_x_position       left edge of the moving block from x_register
//   enable                x_register move enable (MOVE only)
//   load_x/load_direction x_register load strobes (SPAWN only)
//   new_direction/new_x_position  spawn direction/position
//   block_width, base_x, level, score  game state
//   game_over, win        end-of-game flags
module stack_controller #(
    parameter int unsigned X_MAX      = 144,
    parameter int unsigned INIT_X     = 52,
    parameter int unsigned INIT_WIDTH = 40,
    parameter int unsigned MAX_LEVEL  = 15,
    parameter int unsigned BONUS      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sync,
    input  logic        start,
    input  logic        drop,
    input  logic [7:0]  curr_x_position,
    output logic        enable,
    output logic        load_x,
    output logic        load_direction,
    output logic        new_direction,
    output logic [7:0]  new_x_position,
    output logic [7:0]  block_width,
    output logic [7:0]  base_x,
    output logic [3:0]  level,
    output logic [11:0] score,
    output logic        game_over,
    output logic        win
);

    typedef enum logic [2:0] {
        StIdle, StSpawn, StMove, StSettle, StCompare, StUpdate, StGameOver, StWin
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  width_q, width_d;
    logic [7:0]  base_q, base_d;
    logic [3:0]  level_q, level_d;
    logic [11:0] score_q, score_d;
    logic [8:0]  ov_q, ov_d;
    logic [7:0]  l_q, l_d;

    // Overlap arithmetic; 9 bits holds cx + width without wrap.
    logic [7:0]  left_c;
    logic [8:0]  cx_right_c, base_right_c, right_c, ov_c;
    logic [12:0] score_sum;
    logic [3:0]  level_inc;

    // sync is part of the shared x_register interface but does not steer this FSM.
    logic unused_sync;
    assign unused_sync = sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            width_q <= 8'(INIT_WIDTH);
            base_q  <= 8'(INIT_X);
            level_q <= 4'd0;
            score_q <= 12'd0;
            ov_q    <= 9'd0;
            l_q     <= 8'd0;
        end else begin
            state_q <= state_d;
            width_q <= width_d;
            base_q  <= base_d;
            level_q <= level_d;
            score_q <= score_d;
            ov_q    <= ov_d;
            l_q     <= l_d;
        end
    end

    always_comb begin
        left_c       = (curr_x_position > base_q) ? curr_x_position : base_q;
        cx_right_c   = {1'b0, curr_x_position} + {1'b0, width_q};
        base_right_c = {1'b0, base_q} + {1'b0, width_q};
        right_c      = (cx_right_c < base_right_c) ? cx_right_c : base_right_c;
        ov_c         = (right_c > {1'b0, left_c}) ? (right_c - {1'b0, left_c}) : 9'd0;
        // Perfect placement earns the bonus on top of the overlap.
        score_sum    = {1'b0, score_q} + {4'd0, ov_q}
                     + ((ov_q == {1'b0, width_q}) ? 13'(BONUS) : 13'd0);
        level_inc    = level_q + 4'd1;
    end

    always_comb begin
        state_d        = state_q;
        width_d        = width_q;
        base_d         = base_q;
        level_d        = level_q;
        score_d        = score_q;
        ov_d           = ov_q;
        l_d            = l_q;
        enable         = 1'b0;
        load_x         = 1'b0;
        load_direction = 1'b0;
        new_direction  = 1'b0;
        new_x_position = 8'd0;
        game_over      = 1'b0;
        win            = 1'b0;

        case (state_q)
            StIdle, StGameOver, StWin: begin
                game_over = (state_q == StGameOver);
                win       = (state_q == StWin);
                if (start) begin
                    width_d = 8'(INIT_WIDTH);
                    base_d  = 8'(INIT_X);
                    level_d = 4'd0;
                    score_d = 12'd0;
                    state_d = StSpawn;
                end
            end
            StSpawn: begin
                // Even levels enter from the left moving right, odd from the right.
                load_x         = 1'b1;
                load_direction = 1'b1;
                new_x_position = level_q[0] ? 8'(X_MAX) : 8'd0;
                new_direction  = ~level_q[0];
                state_d        = StMove;
            end
            StMove: begin
                enable = 1'b1;
                if (drop) begin
                    state_d = StSettle;
                end
            end
            // One edge with enable low so curr_x_position is frozen before sampling.
            StSettle: state_d = StCompare;
            StCompare: begin
                ov_d    = ov_c;
                l_d     = left_c;
                state_d = StUpdate;
            end
            StUpdate: begin
                if (ov_q == 9'd0) begin
                    state_d = StGameOver;
                end else begin
                    width_d = ov_q[7:0];
                    base_d  = l_q;
                    score_d = score_sum[12] ? 12'hfff : score_sum[11:0];
                    level_d = level_inc;
                    state_d = (level_inc == 4'(MAX_LEVEL)) ? StWin : StSpawn;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign block_width = width_q;
    assign base_x      = base_q;
    assign level       = level_q;
    assign score       = score_q;

endmodule

// File: tb/tb_stack_controller.sv
// Self-checking bench for stack_controller: table-driven drop vectors with a
// scoreboard queue, plus hand-written reset/ignored-drop/win sequences.
module tb_stack_controller;

    logic        clk = 1'b0;
    logic        reset, sync, start, drop;
    logic [7:0]  curr_x_position;
    logic        enable, load_x, load_direction, new_direction;
    logic [7:0]  new_x_position, block_width, base_x;
    logic [3:0]  level;
    logic [11:0] score;
    logic        game_over, win;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit         fresh;
        logic [7:0] cx;
        int         w;
        int         b;
        int         l;
        int         s;
        bit         go;
        bit         wn;
    } vec_t;

    vec_t sb[$];
    vec_t vecs[5];

    stack_controller dut (
        .clk             (clk),
        .reset           (reset),
        .sync            (sync),
        .start           (start),
        .drop            (drop),
        .curr_x_position (curr_x_position),
        .enable          (enable),
        .load_x          (load_x),
        .load_direction  (load_direction),
        .new_direction   (new_direction),
        .new_x_position  (new_x_position),
        .block_width     (block_width),
        .base_x          (base_x),
        .level           (level),
        .score           (score),
        .game_over       (game_over),
        .win             (win)
    );

    always #5 clk = ~clk;
    always #7 sync = ~sync;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        drop  = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    // Returns at the SPAWN cycle.
    task automatic start_game();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic check_init_values(input string tag);
        check({tag, "_enable"}, int'(enable), 0);
        check({tag, "_load_x"}, int'(load_x), 0);
        check({tag, "_width"}, int'(block_width), 40);
        check({tag, "_base"}, int'(base_x), 52);
        check({tag, "_level"}, int'(level), 0);
        check({tag, "_score"}, int'(score), 0);
    endtask

    task automatic compare_pop(input bit at_spawn);
        vec_t e;
        e = sb.pop_front();
        check("width", int'(block_width), e.w);
        check("base_x", int'(base_x), e.b);
        check("level", int'(level), e.l);
        check("score", int'(score), e.s);
        check("game_over", int'(game_over), int'(e.go));
        check("win", int'(win), int'(e.wn));
        if (at_spawn) begin
            check("spawn_x", int'(new_x_position), (e.l % 2) ? 144 : 0);
            check("spawn_dir", int'(new_direction), (e.l % 2) ? 0 : 1);
            check("spawn_load_dir", int'(load_direction), 1);
        end
    endtask

    task automatic drop_and_check(input vec_t v);
        int t;
        int lowcnt;
        bit done;
        t = 0;
        while (enable !== 1'b1 && t < 20) begin
            step();
            t++;
        end
        if (enable !== 1'b1) begin
            check("move_wait_timeout", 0, 1);
            return;
        end
        curr_x_position = v.cx;
        drop = 1'b1;
        sb.push_back(v);
        step();
        drop = 1'b0;
        lowcnt = 0;
        done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            if (game_over || win) begin
                compare_pop(1'b0);
                done = 1'b1;
            end else if (enable) begin
                done = 1'b1;
            end else begin
                if (load_x && sb.size() != 0) compare_pop(1'b1);
                lowcnt++;
                step();
            end
        end
        if (sb.size() != 0) begin
            check("result_missing", sb.size(), 0);
            sb.delete();
        end
        if (!v.go && !v.wn) check("enable_low_cycles", lowcnt, 4);
    endtask

    initial begin
        vec_t wv;
        bit   en_seen;
        sync = 1'b0;
        curr_x_position = 8'd0;
        // fresh, cx, width, base, level, score, game_over, win
        vecs[0] = '{1'b1, 8'd60,  32, 60, 1, 32, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 8'd70,  22, 70, 2, 54, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 8'd52,  40, 52, 1, 48, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 8'd20,   8, 52, 1,  8, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 8'd100,  8, 52, 1,  8, 1'b1, 1'b0};

        // Reset state
        do_reset();
        check_init_values("rst");
        check("rst_load_dir", int'(load_direction), 0);
        check("rst_new_dir", int'(new_direction), 0);
        check("rst_new_x", int'(new_x_position), 0);
        check("rst_game_over", int'(game_over), 0);
        check("rst_win", int'(win), 0);

        // Drop in IDLE is ignored
        drop = 1'b1;
        step();
        drop = 1'b0;
        step();
        check("idle_drop_enable", int'(enable), 0);
        check("idle_drop_load", int'(load_x), 0);

        // Start: SPAWN then MOVE; drop during SPAWN is ignored
        start = 1'b1;
        step();
        start = 1'b0;
        check("spawn_load_x", int'(load_x), 1);
        check("spawn_load_dir0", int'(load_direction), 1);
        check("spawn_x0", int'(new_x_position), 0);
        check("spawn_dir0", int'(new_direction), 1);
        check("spawn_enable", int'(enable), 0);
        check("spawn_width", int'(block_width), 40);
        check("spawn_base", int'(base_x), 52);
        drop = 1'b1;
        step();
        drop = 1'b0;
        check("move_enable", int'(enable), 1);
        step();
        check("spawn_drop_ignored", int'(enable), 1);

        // Table-driven drops
        for (int k = 0; k < 5; k++) begin
            if (vecs[k].fresh) begin
                do_reset();
                start_game();
            end
            drop_and_check(vecs[k]);
        end

        // Drop in GAME_OVER ignored; start restarts
        drop = 1'b1;
        step();
        drop = 1'b0;
        step();
        step();
        check("go_hold", int'(game_over), 1);
        check("go_score_hold", int'(score), 8);
        start_game();
        check("restart_load_x", int'(load_x), 1);
        check("restart_score", int'(score), 0);
        check("restart_level", int'(level), 0);
        check("restart_width", int'(block_width), 40);
        check("restart_go", int'(game_over), 0);

        // Reset during MOVE with non-initial game state
        drop_and_check(vecs[0]);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_init_values("rst_move");

        // Reset during COMPARE
        start_game();
        drop_and_check(vecs[0]);
        curr_x_position = 8'd60;
        drop = 1'b1;
        step();
        drop = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_init_values("rst_cmp");

        // Drop coinciding with reset is discarded
        start_game();
        step();
        check("pre_rst_drop_enable", int'(enable), 1);
        reset = 1'b1;
        drop = 1'b1;
        step();
        reset = 1'b0;
        drop = 1'b0;
        step();
        step();
        check("rst_drop_enable", int'(enable), 0);
        check("rst_drop_load", int'(load_x), 0);

        // Fifteen perfect drops win
        start_game();
        for (int i = 0; i < 15; i++) begin
            wv = '{1'b0, 8'd52, 40, 52, i + 1, 48 * (i + 1), 1'b0, (i == 14)};
            drop_and_check(wv);
        end
        en_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (enable) en_seen = 1'b1;
        end
        check("win_enable_low", int'(en_seen), 0);
        check("win_flag", int'(win), 1);
        check("win_level", int'(level), 15);
        check("win_score", int'(score), 720);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
